past_sequence_adder: RTL and testbench

- Streaming moving-window adder: every clock it samples one DW-bit input and outputs the sum of the most recent N samples.
- The sum is computed through an adder pipeline of ADDER_REGS register stages, so results appear with fixed latency.
- Intended as a datapath primitive (moving sum / boxcar filter front end) fed by a free-running sample source.

---
 rtl/past_sequence_adder.sv | 61 ++++++
 tb/tb_past_sequence_adder.sv | 121 ++++++++++++
 2 files changed

// File: rtl/past_sequence_adder.sv
// rtl/past_sequence_adder.sv - moving-window sum of the last N samples with a fixed-latency output pipeline
module past_sequence_adder #(
    parameter int N          = 4,
    parameter int DW         = 8,
    parameter int ADDER_REGS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] inp,
    output logic [DW-1:0] outp
);

    logic [DW-1:0] tap_q  [N];
    logic [DW-1:0] tap_d  [N];
    logic [DW-1:0] pipe_q [ADDER_REGS];
    logic [DW-1:0] pipe_d [ADDER_REGS];
    logic [DW-1:0] win_sum;

    always_comb begin
        tap_d[0] = inp;
        for (int i = 1; i < N; i++) begin
            tap_d[i] = tap_q[i-1];
        end
    end

    // Accumulating at DW bits drops every carry out of the top bit, giving the sum modulo 2^DW.
    always_comb begin
        win_sum = '0;
        for (int i = 0; i < N; i++) begin
            win_sum = win_sum + tap_q[i];
        end
    end

    always_comb begin
        pipe_d[0] = win_sum;
        for (int i = 1; i < ADDER_REGS; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                tap_q[i] <= '0;
            end
            for (int i = 0; i < ADDER_REGS; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                tap_q[i] <= tap_d[i];
            end
            for (int i = 0; i < ADDER_REGS; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign outp = pipe_q[ADDER_REGS-1];

endmodule

// File: tb/tb_past_sequence_adder.sv
// tb/tb_past_sequence_adder.sv - randomized self-checking bench for past_sequence_adder
module tb_past_sequence_adder;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AR = 4;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] inp;
    logic [DW-1:0] outp;

    int checks;
    int failures;
    int hist[$];

    past_sequence_adder #(.N(N), .DW(DW), .ADDER_REGS(AR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .inp   (inp),
        .outp  (outp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Output after the latest edge: sum of the N samples ending AR edges ago, unfilled history as 0.
    function automatic logic [DW-1:0] model_out();
        int e;
        int s;
        e = hist.size() - 1;
        s = 0;
        if (e - AR < 0) return '0;
        for (int j = e - AR - N + 1; j <= e - AR; j++) begin
            if (j >= 0) s += hist[j];
        end
        return DW'(s % (1 << DW));
    endfunction

    task automatic step(input logic [DW-1:0] v, input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        inp   = v;
        @(posedge clk);
        hist.push_back(int'(v));
        #1;
        check(tag, outp, model_out());
    endtask

    task automatic pulse_reset();
        #1 rst_n = 1'b0;
        #1 check("async_rst", outp, '0);
        hist.delete();
    endtask

    initial begin
        logic [DW-1:0] ramp_exp [10];
        logic [DW-1:0] ff_exp   [8];
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        inp      = '0;
        ramp_exp = '{0, 0, 0, 0, 0, 1, 3, 6, 10, 14};
        ff_exp   = '{0, 0, 0, 0, 8'hFF, 8'hFE, 8'hFD, 8'hFC};

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            inp = DW'($urandom);
            @(posedge clk);
            #1;
            check("rst_hold", outp, '0);
        end

        for (int k = 0; k < 80; k++) begin
            step(DW'(k), "ramp");
            if (k < 10) check("ramp_tab", outp, ramp_exp[k]);
            if (k >= 10) check("ramp_slope", outp, DW'(4 * (k - 4) - 6));
            if (k == 69) check("wrap_254", outp, 8'd254);
            if (k == 70) check("wrap_2", outp, 8'd2);
        end

        for (int k = 0; k < 30; k++) step(DW'(k + 100), "pre_pulse");
        pulse_reset();
        for (int k = 0; k < 12; k++) begin
            step(DW'(k), "ramp_after_rst");
            if (k < 10) check("ramp2_tab", outp, ramp_exp[k]);
        end

        pulse_reset();
        for (int k = 0; k < 12; k++) begin
            step(8'hFF, "const_ff");
            check("const_ff_tab", outp, (k < 8) ? ff_exp[k] : 8'hFC);
        end

        pulse_reset();
        for (int k = 0; k < 14; k++) begin
            step((k == 2) ? 8'd5 : 8'd0, "impulse");
            check("impulse_tab", outp, (k >= 6 && k <= 9) ? 8'd5 : 8'd0);
        end

        pulse_reset();
        for (int k = 0; k < 300; k++) begin
            step(DW'($urandom), "random");
            if ($urandom_range(0, 99) == 0) pulse_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
